// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder and its byte FIFO.
package uart_pkg;
    localparam int MAX_WR_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;
endpackage

// File: rtl/uart_byte_fifo.sv
// Byte storage: 4-lane write at consecutive addresses from a base pointer, 1-byte head read.
// Pointers and occupancy are owned by the caller; contents are not reset.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic [MAX_WR_BYTES-1:0]   lane_en_i,
    input  logic [PW-1:0]             wr_base_i,
    input  logic [8*MAX_WR_BYTES-1:0] wr_data_i,
    input  logic [PW-1:0]             rd_ptr_i,
    output logic [7:0]                head_o
);
    logic [7:0] mem_q [DEPTH];

    // Lane i lands at base+i; the PW-bit add wraps a straddling word naturally.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_WR_BYTES; i++) begin
            if (lane_en_i[i]) begin
                mem_q[wr_base_i + PW'(i)] <= wr_data_i[8*i +: 8];
            end
        end
    end

    assign head_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/uart_tx_feeder.sv
// Unpacks 1..4-byte words into a byte FIFO and feeds a UART one byte per tx_start pulse.
// First tx_start two cycles after the handshake; wr_ready drops while fewer than 4 slots are free.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            wr_data,
    input  logic [2:0]             wr_bytes,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [7:0]             sdata,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle,
    output logic                   err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    err_q;
    state_e                  state_q;
    logic                    tx_start_q;
    logic [7:0]              sdata_q;

    logic                    hs;
    logic                    legal;
    logic                    push;
    logic                    pop;
    logic [MAX_WR_BYTES-1:0] lane_en;
    logic [7:0]              head;

    // Room for a full word is required regardless of wr_bytes, so overflow cannot happen.
    assign wr_ready = (count_q <= CW'(DEPTH - MAX_WR_BYTES));
    assign hs       = wr_valid && wr_ready;
    assign legal    = (wr_bytes != 3'd0) && (wr_bytes <= 3'(MAX_WR_BYTES));
    assign push     = hs && legal;
    assign pop      = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < MAX_WR_BYTES; i++) begin
            lane_en[i] = push && (3'(i) < wr_bytes);
        end
    end

    always_comb begin
        count_d  = count_q + (push ? CW'(wr_bytes) : CW'(0)) - CW'(pop);
        wr_ptr_d = wr_ptr_q + (push ? PW'(wr_bytes) : PW'(0));
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .lane_en_i (lane_en),
        .wr_base_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_ptr_i  (rd_ptr_q),
        .head_o    (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_q | (hs && !legal);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            sdata_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        sdata_q    <= head;
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign sdata    = sdata_q;
    assign tx_start = tx_start_q;
    assign count    = count_q;
    assign err      = err_q;
    assign idle     = (count_q == '0) && (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised bench for uart_tx_feeder against a byte-queue reference model.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wr_data = '0;
    logic [2:0]  wr_bytes = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  sdata;
    logic        tx_start;
    logic        tx_busy;
    logic [4:0]  count;
    logic        idle;
    logic        err;

    logic        hold = 1'b0;
    int          bcnt = 0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         err_m = 0;
    bit         mon_en = 0;
    int         ncyc = 0;
    int         tx_n = 0;
    int         peak = 0;
    int         max_cnt = 0;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_bytes (wr_bytes),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .count    (count),
        .idle     (idle),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy on the start pulse and for 20 cycles after it.
    always @(posedge clk) begin
        if (tx_start) bcnt <= 20;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = hold || tx_start || (bcnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: per-cycle comparison against the queue model.
    initial begin
        logic [7:0] exp_b;
        logic [7:0] last_sd;
        bit rst_prev, busy_prev, hold_prev, start_prev, lat_arm, gap_arm;
        int lat_cyc, gap_cyc;
        last_sd = 8'h00;
        rst_prev = 0; busy_prev = 0; hold_prev = 0; start_prev = 0;
        lat_arm = 0; gap_arm = 0; lat_cyc = 0; gap_cyc = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ncyc++;
                if (rst_prev) begin
                    q.delete();
                    err_m = 0;
                    last_sd = 8'h00;
                    lat_arm = 0;
                    gap_arm = 0;
                end
                if (tx_start) begin
                    tx_n++;
                    chk("pulse_1cyc", 32'(start_prev), 0);
                    if (q.size() == 0) begin
                        chk("spurious_start", 1, 0);
                    end else begin
                        exp_b = q.pop_front();
                        chk("sdata", sdata, exp_b);
                        last_sd = exp_b;
                    end
                    if (lat_arm) begin
                        chk("first_latency", ncyc - lat_cyc, 2);
                        lat_arm = 0;
                    end
                    if (gap_arm) begin
                        chk("interbyte_gap", ncyc - gap_cyc, 2);
                        gap_arm = 0;
                    end
                end else begin
                    chk("sdata_hold", sdata, last_sd);
                end
                chk("count", count, q.size());
                chk("wr_ready", wr_ready, 32'(DEPTH - q.size() >= 4));
                chk("err", err, 32'(err_m));
                if (q.size() != 0) chk("idle_nonempty", idle, 0);
                if (int'(count) > peak) peak = count;
                if (int'(count) > max_cnt) max_cnt = count;
                if (busy_prev && !tx_busy && !hold && !hold_prev && !rst && q.size() > 0) begin
                    gap_arm = 1;
                    gap_cyc = ncyc;
                end
                if (!rst && wr_valid && (DEPTH - q.size() >= 4)) begin
                    if (wr_bytes >= 1 && wr_bytes <= 4) begin
                        if (q.size() == 0 && idle && !tx_busy) begin
                            lat_arm = 1;
                            lat_cyc = ncyc;
                        end
                        for (int i = 0; i < int'(wr_bytes); i++) q.push_back(wr_data[8*i +: 8]);
                    end else begin
                        err_m = 1;
                    end
                end
                rst_prev   = rst;
                busy_prev  = tx_busy;
                hold_prev  = hold;
                start_prev = tx_start;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] n);
        bit acc;
        acc = 0;
        @(posedge clk);
        #1;
        wr_data  = d;
        wr_bytes = n;
        wr_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (idle && !tx_busy && bcnt == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int base;
        int total;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_wr_ready", wr_ready, 1);
        mon_en = 1;

        // Single full word, sent in little-endian order
        base = tx_n;
        send(32'h44332211, 3'd4);
        wait_idle();
        chk("w4_bytes_sent", tx_n - base, 4);
        chk("w4_idle", idle, 1);

        // Two short words queued behind a busy transmitter
        hold = 1'b1;
        peak = 0;
        base = tx_n;
        send({$urandom_range(0, 65535), 16'hBBAA}, 3'd2);
        send({$urandom_range(0, 16777215), 8'hCC}, 3'd1);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_idle();
        chk("short_bytes_sent", tx_n - base, 3);
        chk("short_peak", peak, 3);

        // Fill to capacity; a fifth word must stall
        hold = 1'b1;
        base = tx_n;
        for (int w = 0; w < 4; w++) send($urandom, 3'd4);
        @(negedge clk);
        chk("full_count", count, 16);
        chk("full_wr_ready", wr_ready, 0);
        @(posedge clk);
        #1;
        wr_data  = $urandom;
        wr_bytes = 3'd4;
        wr_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_stall", wr_ready, 0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        hold = 1'b0;
        wait_idle();
        chk("full_drained", tx_n - base, 16);

        // Illegal byte counts
        base = tx_n;
        send($urandom, 3'd0);
        send($urandom, 3'd5);
        repeat (4) @(negedge clk);
        chk("bad_err", err, 1);
        chk("bad_count", count, 0);
        chk("bad_no_start", tx_n - base, 0);

        // Random writes with concurrent draining, crossing the pointer wrap
        base = tx_n;
        total = 0;
        max_cnt = 0;
        for (int w = 0; w < 40; w++) begin
            int n;
            n = $urandom_range(1, 4);
            repeat ($urandom_range(0, 25)) @(posedge clk);
            send($urandom, 3'(n));
            total += n;
        end
        wait_idle();
        chk("rand_bytes_sent", tx_n - base, total);
        chk("rand_max_count", 32'(max_cnt <= DEPTH), 1);

        // Reset landing in the S_START cycle
        hold = 1'b1;
        send($urandom, 3'd4);
        send($urandom, 3'd3);
        @(posedge clk);
        #1;
        hold = 1'b0;
        base = tx_n;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                #1;
                if (tx_start) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) chk("rst_start_timeout", 0, 1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_count", count, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_err", err, 0);
        repeat (60) @(negedge clk);
        chk("midrst_no_more_start", tx_n - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end
endmodule
